vend_sequencer: RTL and testbench
=================================

Name: vend_sequencer

Overview:
- Top-level controller for the coin-operated vending datapath.
- Accumulates coin credit and accepts a product selection against a per-item price table.
- Sequences the dispenser over a req/ack handshake, then returns change one coin at a time over a second req/ack handshake.
- Supports cancel/refund and an inactivity timeout.

Parameters:
- PRICE_A, 3, price of item A in 5-unit coins (3 = 15).
- PRICE_B, 4, price of item B in 5-unit coins (4 = 20).
- PRICE_C, 5, price of item C in 5-unit coins (5 = 25).
- MAX_CREDIT, 10, credit ceiling in 5-unit coins.
- TIMEOUT, 200, idle cycles in COLLECT before auto-refund.
- CREDIT_W, 4, width of the credit register. Must hold MAX_CREDIT.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- coin  input  2  coin event, one cycle per coin: 00 none, 01 = 5 (1 unit), 10 = 10 (2 units), 11 invalid.
- sel  input  2  selection strobe: 00 none, 01 A, 10 B, 11 C.
- cancel  input  1  refund request, single-cycle pulse.
- disp_ack  input  1  dispenser has delivered the item.
- chg_ack  input  1  change hopper has ejected the current coin.
- disp_req  output  1  dispense request; held until disp_ack.
- disp_item  output  2  item code; stable while disp_req is high.
- chg_req  output  1  change-coin request; held until chg_ack.
- chg_coin  output  2  coin to eject: 10 = 10, 01 = 5; stable while chg_req is high.
- credit  output  CREDIT_W  current credit in 5-unit coins.
- coin_reject  output  1  one-cycle pulse when a coin is refused.
- busy  output  1  high in VEND and CHANGE.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - credit=0, timer=0.
  - All outputs 0: disp_req, disp_item, chg_req, chg_coin, coin_reject, busy.
  - Reset mid-vend or mid-change abandons the transaction and loses credit; no handshake completes.
- States: IDLE, COLLECT, VEND, CHANGE. Registered outputs; a coin or strobe sampled at edge n is reflected at n+1.
- IDLE:
  - A valid coin (01/10) adds 1/2 units to credit and moves to COLLECT.
  - sel and cancel are ignored.
- COLLECT:
  - Any accepted coin adds its value to credit and resets timer.
  - A coin that would push credit above MAX_CREDIT is rejected: credit unchanged, coin_reject=1 for one cycle.
  - Coin 11 is always rejected the same way.
  - sel!=00 with credit >= price:
    - latch disp_item=sel;
    - credit -= price;
    - assert disp_req next cycle;
    - go to VEND.
  - sel with credit < price: ignored, state and credit unchanged.
  - cancel, or timer reaching TIMEOUT-1: go to CHANGE with the full credit.
  - timer increments each cycle with no accepted coin.
- Priority in COLLECT when events coincide:
  - cancel beats sel, sel beats coin.
  - A coin arriving in the same cycle as a taken sel or cancel is rejected (coin_reject pulses).
- VEND:
  - disp_req held high until the cycle disp_ack=1 is sampled; disp_req drops next cycle.
  - Then go to CHANGE if credit>0, else IDLE.
  - Coins are rejected; sel and cancel are ignored.
- CHANGE:
  - chg_req=1; chg_coin=10 if credit>=2, else 01.
  - On sampled chg_ack, credit decreases by the coin value and chg_req drops for one cycle.
  - chg_req re-asserts while credit>0; go to IDLE when credit reaches 0.
  - Coins are rejected; cancel is ignored.
- An ack while its req is low is ignored.
- credit never underflows or exceeds MAX_CREDIT.

Test Plan:
- Exact price:
  - Stimulus: coins 01,01,01 then sel=01.
  - Response: credit reads 1,2,3; disp_req=1, disp_item=01, credit=0.
  - Then: disp_ack → IDLE with no chg_req.
- Overpay:
  - Stimulus: coins 10,10,10 (credit 6), then sel=10 (price 4).
  - Response: credit=2, VEND.
  - Then: after disp_ack, one chg_req with chg_coin=10; after chg_ack → IDLE, credit=0.
- Insufficient and cancel:
  - Stimulus: coin 10 (credit 2), sel=11.
  - Response: ignored, credit stays 2.
  - Then: cancel → chg_coin=10, refund, IDLE.
- Saturation and invalid coin:
  - Stimulus: reach credit 10, then coin 01, then coin 11.
  - Response: each produces a coin_reject pulse; credit stays 10.
- Simultaneous events:
  - Stimulus: credit 3, then sel=01 together with coin=10.
  - Response: vend A, credit 0, coin_reject=1.
  - Stimulus: cancel together with sel.
  - Response: refund, no disp_req.
- Timeout and reset:
  - Stimulus: credit 3, no activity for TIMEOUT cycles.
  - Response: change sequence 10 then 01.
  - Stimulus: assert rst while chg_req=1.
  - Response: all outputs 0 immediately, credit=0.

Source files
------------

// File: rtl/vend_sequencer.sv
// -----------------------------------------------------------------------------
// vend_sequencer
// Top-level controller for the coin-operated vending datapath. Collects coin
// credit, accepts a product selection against a per-item price table,
// sequences the dispenser over a req/ack handshake and then returns change
// one coin at a time over a second req/ack handshake. Supports cancel/refund
// and an inactivity timeout in the collect phase.
//
// Ports:
//   i_clk          clock, all state updates on the rising edge
//   i_rst          asynchronous active-high reset
//   i_coin   [1:0] coin event: 00 none, 01 = one unit, 10 = two units, 11 invalid
//   i_sel    [1:0] selection strobe: 00 none, 01 A, 10 B, 11 C
//   i_cancel       refund request pulse
//   i_disp_ack     dispenser delivered the item
//   i_chg_ack      change hopper ejected the current coin
//   o_disp_req     dispense request, held until i_disp_ack is sampled
//   o_disp_item    item code, stable while o_disp_req is high
//   o_chg_req      change-coin request, held until i_chg_ack is sampled
//   o_chg_coin     coin to eject: 10 = two units, 01 = one unit
//   o_credit       current credit in coin units
//   o_coin_reject  one-cycle pulse when a coin is refused
//   o_busy         high while vending or returning change
// -----------------------------------------------------------------------------
module vend_sequencer #(
   parameter int PRICE_A    = 3,
   parameter int PRICE_B    = 4,
   parameter int PRICE_C    = 5,
   parameter int MAX_CREDIT = 10,
   parameter int TIMEOUT    = 200,
   parameter int CREDIT_W   = 4
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [1:0]          i_coin,
   input  logic [1:0]          i_sel,
   input  logic                i_cancel,
   input  logic                i_disp_ack,
   input  logic                i_chg_ack,
   output logic                o_disp_req,
   output logic [1:0]          o_disp_item,
   output logic                o_chg_req,
   output logic [1:0]          o_chg_coin,
   output logic [CREDIT_W-1:0] o_credit,
   output logic                o_coin_reject,
   output logic                o_busy
);

   localparam int TIMER_W = $clog2(TIMEOUT + 1);

   localparam logic [CREDIT_W-1:0] CREDIT_ZERO = {CREDIT_W{1'b0}};
   localparam logic [CREDIT_W-1:0] CREDIT_ONE  = {{(CREDIT_W-1){1'b0}}, 1'b1};
   localparam logic [CREDIT_W-1:0] CREDIT_TWO  = {{(CREDIT_W-2){1'b0}}, 2'b10};
   localparam logic [CREDIT_W-1:0] P_A         = CREDIT_W'(PRICE_A);
   localparam logic [CREDIT_W-1:0] P_B         = CREDIT_W'(PRICE_B);
   localparam logic [CREDIT_W-1:0] P_C         = CREDIT_W'(PRICE_C);
   localparam logic [CREDIT_W:0]   MAX_EXT     = (CREDIT_W+1)'(MAX_CREDIT);
   localparam logic [TIMER_W-1:0]  TIMER_ZERO  = {TIMER_W{1'b0}};
   localparam logic [TIMER_W-1:0]  TIMER_ONE   = {{(TIMER_W-1){1'b0}}, 1'b1};
   localparam logic [TIMER_W-1:0]  TIMER_LAST  = TIMER_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_VEND    = 2'd2,
      S_CHANGE  = 2'd3
   } state_t;

   // Credit value of a coin code; the invalid code is worth nothing.
   function automatic logic [CREDIT_W-1:0] coin_units(input logic [1:0] coin);
      logic [CREDIT_W-1:0] units;
      case (coin)
         2'b01:   units = CREDIT_ONE;
         2'b10:   units = CREDIT_TWO;
         default: units = CREDIT_ZERO;
      endcase
      return units;
   endfunction

   // Price of the selected item.
   function automatic logic [CREDIT_W-1:0] price_of(input logic [1:0] sel);
      logic [CREDIT_W-1:0] price;
      case (sel)
         2'b01:   price = P_A;
         2'b10:   price = P_B;
         default: price = P_C;
      endcase
      return price;
   endfunction

   // Largest coin that does not overdraw the remaining credit.
   function automatic logic [1:0] change_coin(input logic [CREDIT_W-1:0] credit);
      logic [1:0] coin;
      if (credit >= CREDIT_TWO) begin
         coin = 2'b10;
      end else begin
         coin = 2'b01;
      end
      return coin;
   endfunction

   state_t              r_state,       w_state;
   logic [CREDIT_W-1:0] r_credit,      w_credit;
   logic [TIMER_W-1:0]  r_timer,       w_timer;
   logic                r_disp_req,    w_disp_req;
   logic [1:0]          r_disp_item,   w_disp_item;
   logic                r_chg_req,     w_chg_req;
   logic [1:0]          r_chg_coin,    w_chg_coin;
   logic                r_coin_reject, w_coin_reject;
   logic                r_busy,        w_busy;

   logic [CREDIT_W-1:0] w_coin_units;
   logic                w_coin_valid;
   logic                w_coin_fits;
   logic                w_coin_any;
   logic [CREDIT_W-1:0] w_price;
   logic [CREDIT_W-1:0] w_chg_units;

   assign w_coin_units = coin_units(i_coin);
   assign w_coin_valid = (i_coin == 2'b01) || (i_coin == 2'b10);
   assign w_coin_any   = (i_coin != 2'b00);
   assign w_coin_fits  = (({1'b0, r_credit} + {1'b0, w_coin_units}) <= MAX_EXT);
   assign w_price      = price_of(i_sel);
   assign w_chg_units  = coin_units(r_chg_coin);

   // Next-state and next-output computation for the sequencer.
   always_comb begin
      w_state       = r_state;
      w_credit      = r_credit;
      w_timer       = r_timer;
      w_disp_req    = r_disp_req;
      w_disp_item   = r_disp_item;
      w_chg_req     = r_chg_req;
      w_chg_coin    = r_chg_coin;
      w_coin_reject = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (w_coin_valid) begin
               w_credit = w_coin_units;
               w_timer  = TIMER_ZERO;
               w_state  = S_COLLECT;
            end else begin
               w_coin_reject = (i_coin == 2'b11);
            end
         end

         // Priority: cancel, then an affordable selection, then a coin,
         // then the inactivity timeout. A coin losing to any of them is refused.
         S_COLLECT: begin
            if (i_cancel) begin
               w_coin_reject = w_coin_any;
               w_state       = S_CHANGE;
               w_chg_req     = 1'b1;
               w_chg_coin    = change_coin(r_credit);
            end else if ((i_sel != 2'b00) && (r_credit >= w_price)) begin
               w_coin_reject = w_coin_any;
               w_credit      = r_credit - w_price;
               w_disp_item   = i_sel;
               w_disp_req    = 1'b1;
               w_state       = S_VEND;
            end else if (w_coin_valid && w_coin_fits) begin
               w_credit = r_credit + w_coin_units;
               w_timer  = TIMER_ZERO;
            end else if (r_timer == TIMER_LAST) begin
               w_coin_reject = w_coin_any;
               w_state       = S_CHANGE;
               w_chg_req     = 1'b1;
               w_chg_coin    = change_coin(r_credit);
            end else begin
               w_coin_reject = w_coin_any;
               w_timer       = r_timer + TIMER_ONE;
            end
         end

         S_VEND: begin
            w_coin_reject = w_coin_any;
            if (r_disp_req && i_disp_ack) begin
               w_disp_req = 1'b0;
               if (r_credit != CREDIT_ZERO) begin
                  w_state    = S_CHANGE;
                  w_chg_req  = 1'b1;
                  w_chg_coin = change_coin(r_credit);
               end else begin
                  w_state = S_IDLE;
               end
            end else begin
               w_disp_req = r_disp_req;
            end
         end

         // After each ejected coin the request drops for one cycle, then
         // re-asserts with the next coin while credit remains.
         S_CHANGE: begin
            w_coin_reject = w_coin_any;
            if (r_chg_req && i_chg_ack) begin
               w_chg_req = 1'b0;
               if (r_credit > w_chg_units) begin
                  w_credit = r_credit - w_chg_units;
               end else begin
                  w_credit = CREDIT_ZERO;
                  w_state  = S_IDLE;
               end
            end else if (!r_chg_req && (r_credit != CREDIT_ZERO)) begin
               w_chg_req  = 1'b1;
               w_chg_coin = change_coin(r_credit);
            end else begin
               w_chg_req = r_chg_req;
            end
         end

         default: begin
            w_state    = S_IDLE;
            w_credit   = CREDIT_ZERO;
            w_timer    = TIMER_ZERO;
            w_disp_req = 1'b0;
            w_chg_req  = 1'b0;
         end
      endcase

      w_busy = (w_state == S_VEND) || (w_state == S_CHANGE);
   end

   // State and registered-output update with asynchronous reset.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state       <= S_IDLE;
         r_credit      <= CREDIT_ZERO;
         r_timer       <= TIMER_ZERO;
         r_disp_req    <= 1'b0;
         r_disp_item   <= 2'b00;
         r_chg_req     <= 1'b0;
         r_chg_coin    <= 2'b00;
         r_coin_reject <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         r_state       <= w_state;
         r_credit      <= w_credit;
         r_timer       <= w_timer;
         r_disp_req    <= w_disp_req;
         r_disp_item   <= w_disp_item;
         r_chg_req     <= w_chg_req;
         r_chg_coin    <= w_chg_coin;
         r_coin_reject <= w_coin_reject;
         r_busy        <= w_busy;
      end
   end

   assign o_disp_req    = r_disp_req;
   assign o_disp_item   = r_disp_item;
   assign o_chg_req     = r_chg_req;
   assign o_chg_coin    = r_chg_coin;
   assign o_credit      = r_credit;
   assign o_coin_reject = r_coin_reject;
   assign o_busy        = r_busy;

endmodule

// File: tb/tb_vend_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vend_sequencer
// Self-checking bench for vend_sequencer: a table of directed vectors, a few
// hand-written multi-cycle sequences (saturation, timeout, reset mid-change)
// and a randomized run compared against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_vend_sequencer;

   localparam int PRICE_A    = 3;
   localparam int PRICE_B    = 4;
   localparam int PRICE_C    = 5;
   localparam int MAX_CREDIT = 10;
   localparam int TIMEOUT    = 200;
   localparam int CREDIT_W   = 4;
   localparam int NVEC       = 29;

   logic                clk;
   logic                rst;
   logic [1:0]          coin;
   logic [1:0]          sel;
   logic                cancel;
   logic                disp_ack;
   logic                chg_ack;
   logic                disp_req;
   logic [1:0]          disp_item;
   logic                chg_req;
   logic [1:0]          chg_coin;
   logic [CREDIT_W-1:0] credit;
   logic                coin_reject;
   logic                busy;

   int checks   = 0;
   int failures = 0;

   vend_sequencer #(
      .PRICE_A(PRICE_A), .PRICE_B(PRICE_B), .PRICE_C(PRICE_C),
      .MAX_CREDIT(MAX_CREDIT), .TIMEOUT(TIMEOUT), .CREDIT_W(CREDIT_W)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_coin(coin), .i_sel(sel), .i_cancel(cancel),
      .i_disp_ack(disp_ack), .i_chg_ack(chg_ack),
      .o_disp_req(disp_req), .o_disp_item(disp_item), .o_chg_req(chg_req),
      .o_chg_coin(chg_coin), .o_credit(credit), .o_coin_reject(coin_reject),
      .o_busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] coin;
      logic [1:0] sel;
      logic       cancel;
      logic       dack;
      logic       cack;
      int         cr, dr, di, cq, cc, rj, bz;
   } vec_t;

   vec_t vecs [NVEC];

   function automatic vec_t mk(input logic [1:0] c, input logic [1:0] s,
                               input logic cn, input logic da, input logic ca,
                               input int cr, input int dr, input int di, input int cq,
                               input int cc, input int rj, input int bz);
      vec_t v;
      v.coin = c; v.sel = s; v.cancel = cn; v.dack = da; v.cack = ca;
      v.cr = cr; v.dr = dr; v.di = di; v.cq = cq; v.cc = cc; v.rj = rj; v.bz = bz;
      return v;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input int cr, input int dr, input int di,
                            input int cq, input int cc, input int rj, input int bz);
      check({tag, " credit"},      int'(credit),      cr);
      check({tag, " disp_req"},    int'(disp_req),    dr);
      check({tag, " disp_item"},   int'(disp_item),   di);
      check({tag, " chg_req"},     int'(chg_req),     cq);
      check({tag, " chg_coin"},    int'(chg_coin),    cc);
      check({tag, " coin_reject"}, int'(coin_reject), rj);
      check({tag, " busy"},        int'(busy),        bz);
   endtask

   // Drive one cycle of inputs on the falling edge, return just after the rising edge.
   task automatic step(input logic [1:0] c, input logic [1:0] s, input logic cn,
                       input logic da, input logic ca);
      @(negedge clk);
      coin = c; sel = s; cancel = cn; disp_ack = da; chg_ack = ca;
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model (transaction level) ----------------
   typedef enum {M_IDLE, M_COLLECT, M_VEND, M_CHANGE} mphase_t;
   mphase_t m_phase;
   int m_credit, m_idle, m_dreq, m_item, m_creq, m_ccoin, m_rej;
   int m_refund [$];

   // Change is paid largest coin first: all the 10s, then one 5 if odd.
   task automatic m_start_refund();
      m_phase = M_CHANGE;
      m_refund.delete();
      for (int k = 0; k < m_credit / 2; k++) m_refund.push_back(2);
      if (m_credit % 2 == 1) m_refund.push_back(1);
      m_creq  = 1;
      m_ccoin = m_refund[0];
   endtask

   task automatic m_reset();
      m_phase = M_IDLE; m_credit = 0; m_idle = 0; m_dreq = 0; m_item = 0;
      m_creq = 0; m_ccoin = 0; m_rej = 0;
      m_refund.delete();
   endtask

   task automatic model_step(input int c, input int s, input int cn, input int da, input int ca);
      int units, price;
      units = (c == 1) ? 1 : ((c == 2) ? 2 : 0);
      price = (s == 1) ? PRICE_A : ((s == 2) ? PRICE_B : PRICE_C);
      m_rej = 0;
      case (m_phase)
         M_IDLE: begin
            if (units > 0) begin
               m_credit = units; m_idle = 0; m_phase = M_COLLECT;
            end else m_rej = (c == 3) ? 1 : 0;
         end
         M_COLLECT: begin
            if (cn != 0) begin
               m_rej = (c != 0) ? 1 : 0;
               m_start_refund();
            end else if (s != 0 && m_credit >= price) begin
               m_rej = (c != 0) ? 1 : 0;
               m_credit -= price; m_item = s; m_dreq = 1; m_phase = M_VEND;
            end else if (units > 0 && m_credit + units <= MAX_CREDIT) begin
               m_credit += units; m_idle = 0;
            end else if (m_idle == TIMEOUT - 1) begin
               m_rej = (c != 0) ? 1 : 0;
               m_start_refund();
            end else begin
               m_rej = (c != 0) ? 1 : 0;
               m_idle++;
            end
         end
         M_VEND: begin
            m_rej = (c != 0) ? 1 : 0;
            if (m_dreq == 1 && da != 0) begin
               m_dreq = 0;
               if (m_credit > 0) m_start_refund();
               else m_phase = M_IDLE;
            end
         end
         default: begin
            m_rej = (c != 0) ? 1 : 0;
            if (m_creq == 1 && ca != 0) begin
               m_credit -= m_refund.pop_front();
               m_creq = 0;
               if (m_refund.size() == 0) m_phase = M_IDLE;
            end else if (m_creq == 0) begin
               m_creq = 1; m_ccoin = m_refund[0];
            end
         end
      endcase
   endtask

   // ---------------- test sequence ----------------
   initial begin
      //                 coin   sel   cn    da    ca     cr dr di cq cc rj bz
      vecs[0]  = mk(2'd1, 2'd0, 1'b0, 1'b0, 1'b0,  1, 0, 0, 0, 0, 0, 0);
      vecs[1]  = mk(2'd1, 2'd0, 1'b0, 1'b0, 1'b0,  2, 0, 0, 0, 0, 0, 0);
      vecs[2]  = mk(2'd1, 2'd0, 1'b0, 1'b0, 1'b0,  3, 0, 0, 0, 0, 0, 0);
      vecs[3]  = mk(2'd0, 2'd1, 1'b0, 1'b0, 1'b0,  0, 1, 1, 0, 0, 0, 1);
      vecs[4]  = mk(2'd0, 2'd0, 1'b0, 1'b0, 1'b0,  0, 1, 1, 0, 0, 0, 1);
      vecs[5]  = mk(2'd0, 2'd0, 1'b0, 1'b1, 1'b0,  0, 0, 1, 0, 0, 0, 0);
      vecs[6]  = mk(2'd0, 2'd0, 1'b0, 1'b0, 1'b0,  0, 0, 1, 0, 0, 0, 0);
      vecs[7]  = mk(2'd2, 2'd0, 1'b0, 1'b0, 1'b0,  2, 0, 1, 0, 0, 0, 0);
      vecs[8]  = mk(2'd2, 2'd0, 1'b0, 1'b0, 1'b0,  4, 0, 1, 0, 0, 0, 0);
      vecs[9]  = mk(2'd2, 2'd0, 1'b0, 1'b0, 1'b0,  6, 0, 1, 0, 0, 0, 0);
      vecs[10] = mk(2'd0, 2'd2, 1'b0, 1'b0, 1'b0,  2, 1, 2, 0, 0, 0, 1);
      vecs[11] = mk(2'd0, 2'd0, 1'b0, 1'b1, 1'b0,  2, 0, 2, 1, 2, 0, 1);
      vecs[12] = mk(2'd0, 2'd0, 1'b0, 1'b0, 1'b0,  2, 0, 2, 1, 2, 0, 1);
      vecs[13] = mk(2'd0, 2'd0, 1'b0, 1'b0, 1'b1,  0, 0, 2, 0, 2, 0, 0);
      vecs[14] = mk(2'd0, 2'd0, 1'b0, 1'b1, 1'b1,  0, 0, 2, 0, 2, 0, 0);
      vecs[15] = mk(2'd2, 2'd0, 1'b0, 1'b0, 1'b0,  2, 0, 2, 0, 2, 0, 0);
      vecs[16] = mk(2'd0, 2'd3, 1'b0, 1'b0, 1'b0,  2, 0, 2, 0, 2, 0, 0);
      vecs[17] = mk(2'd0, 2'd0, 1'b1, 1'b0, 1'b0,  2, 0, 2, 1, 2, 0, 1);
      vecs[18] = mk(2'd0, 2'd0, 1'b0, 1'b0, 1'b1,  0, 0, 2, 0, 2, 0, 0);
      vecs[19] = mk(2'd1, 2'd0, 1'b0, 1'b0, 1'b0,  1, 0, 2, 0, 2, 0, 0);
      vecs[20] = mk(2'd2, 2'd0, 1'b0, 1'b0, 1'b0,  3, 0, 2, 0, 2, 0, 0);
      vecs[21] = mk(2'd2, 2'd1, 1'b0, 1'b0, 1'b0,  0, 1, 1, 0, 2, 1, 1);
      vecs[22] = mk(2'd0, 2'd0, 1'b0, 1'b1, 1'b0,  0, 0, 1, 0, 2, 0, 0);
      vecs[23] = mk(2'd2, 2'd0, 1'b0, 1'b0, 1'b0,  2, 0, 1, 0, 2, 0, 0);
      vecs[24] = mk(2'd1, 2'd0, 1'b0, 1'b0, 1'b0,  3, 0, 1, 0, 2, 0, 0);
      vecs[25] = mk(2'd0, 2'd1, 1'b1, 1'b0, 1'b0,  3, 0, 1, 1, 2, 0, 1);
      vecs[26] = mk(2'd0, 2'd0, 1'b0, 1'b0, 1'b1,  1, 0, 1, 0, 2, 0, 1);
      vecs[27] = mk(2'd0, 2'd0, 1'b0, 1'b0, 1'b0,  1, 0, 1, 1, 1, 0, 1);
      vecs[28] = mk(2'd0, 2'd0, 1'b0, 1'b0, 1'b1,  0, 0, 1, 0, 1, 0, 0);

      rst = 1'b1; coin = 2'd0; sel = 2'd0; cancel = 1'b0; disp_ack = 1'b0; chg_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all("reset", 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;

      // Directed table: exact price, overpay, insufficient+cancel, simultaneous events.
      for (int i = 0; i < NVEC; i++) begin
         step(vecs[i].coin, vecs[i].sel, vecs[i].cancel, vecs[i].dack, vecs[i].cack);
         check_all($sformatf("vec%0d", i), vecs[i].cr, vecs[i].dr, vecs[i].di,
                   vecs[i].cq, vecs[i].cc, vecs[i].rj, vecs[i].bz);
      end

      // Saturation at MAX_CREDIT and the invalid coin code.
      for (int i = 0; i < 5; i++) step(2'd2, 2'd0, 1'b0, 1'b0, 1'b0);
      check("sat credit", int'(credit), 10);
      step(2'd1, 2'd0, 1'b0, 1'b0, 1'b0);
      check("sat over reject", int'(coin_reject), 1);
      check("sat over credit", int'(credit), 10);
      step(2'd3, 2'd0, 1'b0, 1'b0, 1'b0);
      check("sat invalid reject", int'(coin_reject), 1);
      check("sat invalid credit", int'(credit), 10);
      step(2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      check("sat reject clears", int'(coin_reject), 0);
      step(2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
      check("sat refund req", int'(chg_req), 1);
      for (int k = 0; k < 5; k++) begin
         step(2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
         check("sat drain credit", int'(credit), 10 - 2 * (k + 1));
         check("sat drain gap", int'(chg_req), 0);
         if (k < 4) begin
            step(2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
            check("sat drain req", int'(chg_req), 1);
            check("sat drain coin", int'(chg_coin), 2);
         end
      end
      check("sat drain idle", int'(busy), 0);

      // Inactivity timeout with credit 3, then reset in the middle of change.
      step(2'd2, 2'd0, 1'b0, 1'b0, 1'b0);
      step(2'd1, 2'd0, 1'b0, 1'b0, 1'b0);
      check("to credit", int'(credit), 3);
      for (int i = 1; i < TIMEOUT; i++) begin
         step(2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
         check("to still collecting", int'(busy), 0);
      end
      step(2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      check_all("to fire", 3, 0, 1, 1, 2, 0, 1);
      step(2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
      check_all("to ack1", 1, 0, 1, 0, 2, 0, 1);
      step(2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      check_all("to coin5", 1, 0, 1, 1, 1, 0, 1);
      #2;
      rst = 1'b1;
      #1;
      check_all("mid-change reset", 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;

      // Randomized run against the reference model.
      m_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         int rc, rs, rcn, rda, rca, pick;
         bit quiet;
         quiet = (cyc >= 1000 && cyc < 1210) || (cyc >= 2000 && cyc < 2210);
         pick = $urandom_range(0, 7);
         rc  = (pick < 3) ? 0 : ((pick < 5) ? 1 : ((pick < 7) ? 2 : 3));
         rs  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0;
         rcn = ($urandom_range(0, 19) == 0) ? 1 : 0;
         rda = ($urandom_range(0, 2) == 0) ? 1 : 0;
         rca = ($urandom_range(0, 2) == 0) ? 1 : 0;
         if (quiet) begin
            rc = 0; rs = 0; rcn = 0;
         end
         model_step(rc, rs, rcn, rda, rca);
         step(2'(rc), 2'(rs), 1'(rcn), 1'(rda), 1'(rca));
         check_all($sformatf("rand%0d", cyc), m_credit, m_dreq, m_item, m_creq, m_ccoin,
                   m_rej, (m_phase == M_VEND || m_phase == M_CHANGE) ? 1 : 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
